issue_ctrl: RTL

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_pkg.sv | 37 +++
 rtl/issue_classify.sv | 25 ++
 rtl/issue_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared widths, opcode constants and types for the instruction issue controller.
// Imported by issue_classify and issue_ctrl.
package issue_ctrl_pkg;

    localparam int unsigned INST_W    = 32;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned ROB_POS_W = 4;
    localparam int unsigned OPCODE_W  = 7;

    localparam logic [OPCODE_W-1:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPCODE_BR     = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPCODE_L      = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPCODE_S      = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPCODE_ARITHI = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPCODE_ARITH  = 7'b0110011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Registered issue-port payload.
    typedef struct packed {
        logic                 issue;
        logic                 rs_en;
        logic                 lsb_en;
        logic                 illegal;
        logic [ROB_POS_W-1:0] rob_pos;
        logic [ADDR_W-1:0]    pc;
        logic [INST_W-1:0]    inst;
    } issue_t;

endpackage

// File: rtl/issue_classify.sv
// Opcode decoder: selects the downstream unit for an instruction.
// Opcodes outside the supported set go to the ROB only and are flagged illegal.
module issue_classify
    import issue_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output logic                is_rs,
    output logic                is_lsb,
    output logic                is_illegal
);

    always_comb begin
        is_rs      = 1'b0;
        is_lsb     = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OPCODE_S, OPCODE_L:                                  is_lsb = 1'b1;
            OPCODE_ARITHI, OPCODE_ARITH, OPCODE_JALR, OPCODE_BR: is_rs  = 1'b1;
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL: begin
            end
            default:                                             is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/issue_ctrl.sv
// Single-entry issue stage: buffers one fetched instruction and issues it to RS/LSB/ROB
// when the target unit has room, with rollback flush and a saturating stall counter.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES  = 2,
    parameter int unsigned STALL_CNT_WID = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     inst_rdy,
    input  logic [INST_W-1:0]        inst,
    input  logic [ADDR_W-1:0]        inst_pc,
    output logic                     inst_ack,
    input  logic                     rs_full,
    input  logic                     lsb_full,
    input  logic                     rob_full,
    input  logic [ROB_POS_W-1:0]     nxt_rob_pos,
    input  logic                     rollback,
    output logic                     issue,
    output logic                     rs_en,
    output logic                     lsb_en,
    output logic [INST_W-1:0]        issue_inst,
    output logic [ADDR_W-1:0]        issue_pc,
    output logic [ROB_POS_W-1:0]     rob_pos,
    output logic                     illegal,
    output logic [STALL_CNT_WID-1:0] stall_cnt
);

    localparam int unsigned       FLUSH_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);

    state_t                   state, state_d;
    logic [INST_W-1:0]        hold_inst, hold_inst_d;
    logic [ADDR_W-1:0]        hold_pc, hold_pc_d;
    issue_t                   out_q, out_d;
    logic [STALL_CNT_WID-1:0] stall_q, stall_d;
    logic [FLUSH_W-1:0]       flush_q, flush_d;

    logic cls_rs, cls_lsb, cls_ill;
    logic go, accept;

    issue_classify u_classify (
        .opcode     (hold_inst[OPCODE_W-1:0]),
        .is_rs      (cls_rs),
        .is_lsb     (cls_lsb),
        .is_illegal (cls_ill)
    );

    // The held instruction can leave when the ROB and its own target unit have room.
    assign go       = !rob_full && !(cls_rs && rs_full) && !(cls_lsb && lsb_full);
    assign inst_ack = rdy && !rollback && ((state == ST_IDLE) || ((state == ST_HOLD) && go));
    assign accept   = inst_rdy && inst_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold_inst <= '0;
            hold_pc   <= '0;
            out_q     <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else if (rdy) begin
            state     <= state_d;
            hold_inst <= hold_inst_d;
            hold_pc   <= hold_pc_d;
            out_q     <= out_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    always_comb begin
        state_d       = state;
        hold_inst_d   = hold_inst;
        hold_pc_d     = hold_pc;
        out_d         = out_q;
        out_d.issue   = 1'b0;
        out_d.rs_en   = 1'b0;
        out_d.lsb_en  = 1'b0;
        out_d.illegal = 1'b0;
        stall_d       = stall_q;
        flush_d       = flush_q;

        if (rollback) begin
            state_d = ST_FLUSH;
            flush_d = FLUSH_LOAD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        hold_inst_d = inst;
                        hold_pc_d   = inst_pc;
                        state_d     = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (go) begin
                        out_d.issue   = 1'b1;
                        out_d.rs_en   = cls_rs;
                        out_d.lsb_en  = cls_lsb;
                        out_d.illegal = cls_ill;
                        out_d.rob_pos = nxt_rob_pos;
                        out_d.pc      = hold_pc;
                        out_d.inst    = hold_inst;
                        if (accept) begin
                            hold_inst_d = inst;
                            hold_pc_d   = inst_pc;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (stall_q != '1) begin
                        stall_d = stall_q + STALL_CNT_WID'(1);
                    end
                end
                ST_FLUSH: begin
                    if (flush_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        flush_d = flush_q - FLUSH_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign issue      = out_q.issue;
    assign rs_en      = out_q.rs_en;
    assign lsb_en     = out_q.lsb_en;
    assign illegal    = out_q.illegal;
    assign rob_pos    = out_q.rob_pos;
    assign issue_pc   = out_q.pc;
    assign issue_inst = out_q.inst;
    assign stall_cnt  = stall_q;

endmodule
